seq_mag_comparator: RTL and testbench
=====================================

SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter SLICE, default 4, bits compared per cycle; WIDTH SHALL be an integer multiple of SLICE, with NSL = WIDTH/SLICE.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port CLR_N  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port START  input  1  request a compare; sampled only when the block is not busy.
REQ-006 SHALL have ports A and B  input  WIDTH  operands; captured at the accepting edge.
REQ-007 SHALL have port SIGNED  input  1  1 = two's-complement compare, 0 = unsigned; captured with A and B.
REQ-008 SHALL have ports ALBi, AGBi, AEBi  input  1 each  cascade inputs from a less-significant stage; captured with A and B.
REQ-009 SHALL have port BUSY  output  1  compare in progress.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have ports ALBo, AGBo, AEBo  output  1 each  registered result: A<B, A>B, A==B.

Function
REQ-012 SHALL implement three states: IDLE, CMP, DONE.
REQ-013 IDLE and DONE: START=1 at an edge SHALL capture A, B, SIGNED and the cascade inputs, clear the slice index to 0 (MSB slice) and enter CMP.
REQ-014 CMP: each edge SHALL compare one SLICE-bit slice, MSB slice first, and advance the index by 1.
REQ-015 For a slice whose bits differ, the result SHALL be decided at that edge (ALBo/AGBo per slice order, AEBo=0) and the state SHALL go to DONE (early exit).
REQ-016 If all NSL slices are equal, the result at the last-slice edge SHALL be ALBo=ALBi, AGBo=AGBi, AEBo=AEBi, using the captured cascade values.
REQ-017 Latency: DONE SHALL be high during the cycle after the deciding edge. This is j+1 edges after the START edge for a decision at slice j (0 = MSB), and NSL edges at most.
REQ-018 With SIGNED=1, the MSB bit of the MSB slice SHALL be inverted on both operands before comparison. Other slices SHALL be compared unsigned.
REQ-019 BUSY SHALL be 1 exactly while in CMP.
REQ-020 DONE SHALL be 1 exactly while in DONE, for one cycle. Without START, DONE SHALL then return to IDLE.
REQ-021 START=1 while in DONE SHALL be accepted (back-to-back operation, no idle cycle).
REQ-022 START while in CMP SHALL be ignored and SHALL NOT change the operands.
REQ-023 ALBo/AGBo/AEBo SHALL hold the last result until the next deciding edge; they SHALL NOT change during CMP.
REQ-024 At most one of ALBo, AGBo, AEBo SHALL be 1 for a decided unequal compare. Equal compares SHALL pass the cascade inputs through unmodified, including illegal combinations.

Reset
REQ-025 CLR_N=0 SHALL immediately force IDLE, BUSY=0, DONE=0, ALBo=0, AGBo=0, AEBo=0, slice index=0, and clear the captured registers, regardless of CLK.
REQ-026 Reset during CMP SHALL abort the operation with no DONE pulse. START SHALL be accepted at the first rising edge after CLR_N returns to 1.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, CMP, DONE) and the helper constant computing NSL and the index width, clog2(NSL), minimum 1.
REQ-028 One combinational sub-module mag_slice_cmp SHALL compare two SLICE-bit slices and output lt/gt/eq. The top SHALL instantiate it once and mux the active slice into it.

Verification
REQ-029 WIDTH=16, SLICE=4, unsigned: A=0x1234, B=0x1235, cascade 0/0/1 -> DONE at the 4th edge after START; ALBo=1, AGBo=0, AEBo=0.
REQ-030 A=0x9000, B=0x1FFF, unsigned -> DONE at the 1st edge after START, AGBo=1. The same operands with SIGNED=1 -> ALBo=1.
REQ-031 A=B=0xABCD, cascade ALBi=0, AGBi=1, AEBi=0 -> DONE after 4 edges with ALBo=0, AGBo=1, AEBo=0. A=B with cascade 0/0/1 -> AEBo=1.
REQ-032 Back-to-back: START held high through DONE with new operands -> the second compare starts with no idle cycle; START pulses during BUSY are ignored and the operands are unchanged.
REQ-033 CLR_N pulsed low mid-CMP, asynchronous to CLK -> outputs go to 0 immediately with no DONE pulse; the next START completes normally.
REQ-034 Parameter sweep WIDTH/SLICE in {8/8, 12/4, 32/8} with 1000 random operands each -> results match the arithmetic reference, and DONE latency equals the index of the first differing slice plus 1.

Source files
------------

// File: rtl/seq_mag_comparator_pkg.sv
// Shared state encoding and sizing helpers for the
// slice-serial magnitude comparator.
package seq_mag_comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int nsl_of(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic int idx_w(input int width, input int slice);
    int n;
    n = width / slice;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mag_slice_cmp.sv
// Combinational magnitude compare of one operand slice.
// Exactly one of lt/gt/eq is high.
module mag_slice_cmp #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: one SLICE-bit slice per
// cycle, MSB slice first, early exit on first difference.
module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SIGNED,
  input  logic             ALBi,
  input  logic             AGBi,
  input  logic             AEBi,
  output logic             BUSY,
  output logic             DONE,
  output logic             ALBo,
  output logic             AGBo,
  output logic             AEBo
);

  localparam int NSL = nsl_of(WIDTH, SLICE);
  localparam int IW  = idx_w(WIDTH, SLICE);
  localparam logic [SLICE-1:0] MSB = SLICE'(1) << (SLICE - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [2:0]       cas_q;

  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] flip;
  logic             lt;
  logic             gt;
  logic             eq;
  logic             last;
  logic             accept;
  logic             decide;
  logic             adv;

  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NSL; i++) begin
      if (idx_q == IW'(i)) begin
        sa = a_q[(NSL-1-i)*SLICE +: SLICE];
        sb = b_q[(NSL-1-i)*SLICE +: SLICE];
      end
    end
  end

  // Two's-complement order = unsigned order with sign bit flipped
  assign flip = (sgn_q && idx_q == '0) ? MSB : '0;
  assign last = (idx_q == IW'(NSL - 1));

  mag_slice_cmp #(
    .SLICE(SLICE)
  ) u_slice (
    .a  (sa ^ flip),
    .b  (sb ^ flip),
    .lt (lt),
    .gt (gt),
    .eq (eq)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    decide  = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          accept  = 1'b1;
          state_d = S_CMP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMP: begin
        if (!eq || last) begin
          decide  = 1'b1;
          state_d = S_DONE;
        end else begin
          adv = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      cas_q   <= '0;
      ALBo    <= 1'b0;
      AGBo    <= 1'b0;
      AEBo    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        sgn_q <= SIGNED;
        cas_q <= {ALBi, AGBi, AEBi};
        idx_q <= '0;
      end else if (adv) begin
        idx_q <= idx_q + IW'(1);
      end
      if (decide) begin
        unique case (1'b1)
          lt: {ALBo, AGBo, AEBo} <= 3'b100;
          gt: {ALBo, AGBo, AEBo} <= 3'b010;
          eq: {ALBo, AGBo, AEBo} <= cas_q;
        endcase
      end
    end
  end

  assign BUSY = (state_q == S_CMP);
  assign DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: directed vectors, hand
// sequences and a randomized sweep over four geometries.
module tb_seq_mag_comparator;

  localparam int W[4] = '{16, 8, 12, 32};
  localparam int S[4] = '{4, 8, 4, 8};

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sgn;
  logic [2:0]  cas;
  logic [3:0]  busy;
  logic [3:0]  done;
  logic [3:0]  alb;
  logic [3:0]  agb;
  logic [3:0]  aeb;

  int          checks;
  int          errors;
  int          lat[4];
  int          ndone[4];
  logic [2:0]  res[4];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sg;
    logic [2:0]  cas;
    int          lat;
    logic [2:0]  res;
  } vec_t;

  vec_t vt[10];

  seq_mag_comparator #(.WIDTH(16), .SLICE(4)) u16 (
    .CLK(clk), .CLR_N(clr_n), .START(start),
    .A(a[15:0]), .B(b[15:0]), .SIGNED(sgn),
    .ALBi(cas[2]), .AGBi(cas[1]), .AEBi(cas[0]),
    .BUSY(busy[0]), .DONE(done[0]),
    .ALBo(alb[0]), .AGBo(agb[0]), .AEBo(aeb[0])
  );

  seq_mag_comparator #(.WIDTH(8), .SLICE(8)) u8 (
    .CLK(clk), .CLR_N(clr_n), .START(start),
    .A(a[7:0]), .B(b[7:0]), .SIGNED(sgn),
    .ALBi(cas[2]), .AGBi(cas[1]), .AEBi(cas[0]),
    .BUSY(busy[1]), .DONE(done[1]),
    .ALBo(alb[1]), .AGBo(agb[1]), .AEBo(aeb[1])
  );

  seq_mag_comparator #(.WIDTH(12), .SLICE(4)) u12 (
    .CLK(clk), .CLR_N(clr_n), .START(start),
    .A(a[11:0]), .B(b[11:0]), .SIGNED(sgn),
    .ALBi(cas[2]), .AGBi(cas[1]), .AEBi(cas[0]),
    .BUSY(busy[2]), .DONE(done[2]),
    .ALBo(alb[2]), .AGBo(agb[2]), .AEBo(aeb[2])
  );

  seq_mag_comparator #(.WIDTH(32), .SLICE(8)) u32 (
    .CLK(clk), .CLR_N(clr_n), .START(start),
    .A(a), .B(b), .SIGNED(sgn),
    .ALBi(cas[2]), .AGBi(cas[1]), .AEBi(cas[0]),
    .BUSY(busy[3]), .DONE(done[3]),
    .ALBo(alb[3]), .AGBo(agb[3]), .AEBo(aeb[3])
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_res(input int w, input logic [31:0] x,
                                         input logic [31:0] y, input logic sg,
                                         input logic [2:0] c);
    longint m, va, vb;
    m  = (longint'(1) << w) - 1;
    va = longint'(x) & m;
    vb = longint'(y) & m;
    if (sg && va[w-1]) va = va - (longint'(1) << w);
    if (sg && vb[w-1]) vb = vb - (longint'(1) << w);
    if (va < vb) return 3'b100;
    if (va > vb) return 3'b010;
    return c;
  endfunction

  function automatic int ref_lat(input int w, input int s,
                                 input logic [31:0] x, input logic [31:0] y);
    longint sm, va, vb;
    int n, sh;
    n  = w / s;
    sm = (longint'(1) << s) - 1;
    va = longint'(x);
    vb = longint'(y);
    for (int j = 0; j < n; j++) begin
      sh = w - s * (j + 1);
      if ((((va >> sh) ^ (vb >> sh)) & sm) != 0) return j + 1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic [2:0] tc);
    for (int i = 0; i < 4; i++) begin
      lat[i]   = 0;
      ndone[i] = 0;
      res[i]   = 3'bxxx;
    end
    @(negedge clk);
    a = ta; b = tb_; sgn = ts; cas = tc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          ndone[i]++;
          if (lat[i] == 0) begin
            lat[i] = k;
            res[i] = {alb[i], agb[i], aeb[i]};
          end
        end
      end
    end
  endtask

  task automatic check_dut(input int n, input int i, input logic [31:0] ta,
                           input logic [31:0] tb_, input logic ts,
                           input logic [2:0] tc);
    chk($sformatf("rnd%0d_w%0d_lat", n, W[i]), 64'(lat[i]),
        64'(ref_lat(W[i], S[i], ta, tb_)));
    chk($sformatf("rnd%0d_w%0d_res", n, W[i]), 64'(res[i]),
        64'(ref_res(W[i], ta, tb_, ts, tc)));
    chk($sformatf("rnd%0d_w%0d_pulses", n, W[i]), 64'(ndone[i]), 64'd1);
  endtask

  initial begin
    int          found, lb, mode, nd;
    logic [2:0]  r;
    logic [31:0] ra, rb;
    logic        rs;
    logic [2:0]  rc;

    checks = 0;
    errors = 0;
    clk = 1'b0; clr_n = 1'b0; start = 1'b0;
    a = '0; b = '0; sgn = 1'b0; cas = '0;

    vt[0] = '{16'h1234, 16'h1235, 1'b0, 3'b001, 4, 3'b100};
    vt[1] = '{16'h9000, 16'h1FFF, 1'b0, 3'b000, 1, 3'b010};
    vt[2] = '{16'h9000, 16'h1FFF, 1'b1, 3'b000, 1, 3'b100};
    vt[3] = '{16'hABCD, 16'hABCD, 1'b0, 3'b010, 4, 3'b010};
    vt[4] = '{16'hABCD, 16'hABCD, 1'b0, 3'b001, 4, 3'b001};
    vt[5] = '{16'h0000, 16'h0000, 1'b0, 3'b111, 4, 3'b111};
    vt[6] = '{16'h7FFF, 16'h8000, 1'b1, 3'b000, 1, 3'b010};
    vt[7] = '{16'hFFFF, 16'hFFFE, 1'b1, 3'b001, 4, 3'b010};
    vt[8] = '{16'h1200, 16'h1300, 1'b0, 3'b001, 2, 3'b100};
    vt[9] = '{16'h8000, 16'h8000, 1'b1, 3'b100, 4, 3'b100};

    #2;
    chk("reset_state", 64'({busy, done, alb, agb, aeb}), 64'd0);
    #10 clr_n = 1'b1;

    foreach (vt[t]) begin
      run_op({16'h0, vt[t].a}, {16'h0, vt[t].b}, vt[t].sg, vt[t].cas);
      chk($sformatf("vec%0d_lat", t), 64'(lat[0]), 64'(vt[t].lat));
      chk($sformatf("vec%0d_res", t), 64'(res[0]), 64'(vt[t].res));
      chk($sformatf("vec%0d_pulses", t), 64'(ndone[0]), 64'd1);
    end

    // back-to-back with START held, then a START pulse during BUSY
    @(negedge clk);
    a = 32'h9000; b = 32'h1FFF; sgn = 1'b0; cas = 3'b000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_busy_first", 64'({busy[0], done[0]}), 64'b10);
    a = 32'h0001; b = 32'h0002;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_done_first", 64'({busy[0], done[0]}), 64'b01);
    chk("b2b_res_first", 64'({alb[0], agb[0], aeb[0]}), 64'b010);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_no_idle", 64'({busy[0], done[0]}), 64'b10);
    a = 32'hFFFF; b = 32'h0000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("hold_during_cmp", 64'({alb[0], agb[0], aeb[0]}), 64'b010);
    found = 0; lb = 0; r = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done[0] && found == 0) begin
        found = 1;
        lb = k;
        r = {alb[0], agb[0], aeb[0]};
      end
    end
    chk("b2b_lat_second", 64'(lb), 64'd3);
    chk("b2b_res_second", 64'(r), 64'b100);

    // asynchronous reset in the middle of a compare
    run_op(32'h9000, 32'h1FFF, 1'b0, 3'b000);
    @(negedge clk);
    a = 32'h1234; b = 32'h1235; cas = 3'b001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #3 clr_n = 1'b0;
    #1;
    chk("async_clear", 64'({busy, done, alb, agb, aeb}), 64'd0);
    #7 clr_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done != 4'b0) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    run_op(32'h1234, 32'h1235, 1'b0, 3'b001);
    chk("after_reset_lat", 64'(lat[0]), 64'd4);
    chk("after_reset_res", 64'(res[0]), 64'b100);

    // randomized sweep across all four geometries
    for (int n = 0; n < 1000; n++) begin
      ra   = $urandom;
      mode = $urandom_range(3, 0);
      unique case (mode)
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'h1 << $urandom_range(31, 0));
        default: rb = ra ^ ($urandom & ((32'h1 << $urandom_range(31, 0)) - 1));
      endcase
      rs = 1'($urandom_range(1, 0));
      rc = 3'($urandom_range(7, 0));
      run_op(ra, rb, rs, rc);
      for (int i = 0; i < 4; i++) check_dut(n, i, ra, rb, rs, rc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
